// File: rtl/coffee_machine_pkg.sv
// -----------------------------------------------------------------------------
// coffee_machine_pkg
//  Shared definitions for the coin-operated coffee vending controller:
//  FSM state encoding and the default pricing / timing constants used as
//  parameter defaults by the top level.
// -----------------------------------------------------------------------------
package coffee_machine_pkg;

  // Controller states; the encoding is fixed (IDLE=0 .. COIN_OUT=4).
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COIN_IN  = 3'd1,
    READY    = 3'd2,
    COFFEE   = 3'd3,
    COIN_OUT = 3'd4
  } state_e;

  // Default constants.
  localparam int unsigned COIN_UNIT_DEF      = 100;
  localparam int unsigned PRICE_DEF          = 300;
  localparam int unsigned MAX_VAL_DEF        = 9900;
  localparam int unsigned RETURN_CYCLES_DEF  = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

endpackage

// File: rtl/coffee_machine_rise_edge_det.sv
// -----------------------------------------------------------------------------
// rise_edge_det
//  Rising-edge detector for one level input. The pulse is combinational
//  against a one-cycle delayed copy, so the consumer sees the edge at the
//  same clock edge that first samples the input high.
// Ports:
//  clk      in   system clock
//  rst_n    in   asynchronous active-low reset (history register cleared)
//  in_i     in   level input
//  pulse_o  out  in_i & ~in_q, high for one cycle per rising edge
// -----------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic pulse_o
);

  logic in_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_i;
    end
  end

  assign pulse_o = in_i & ~in_q;

endmodule

// File: rtl/coffee_machine.sv
// -----------------------------------------------------------------------------
// coffee_machine
//  Coin-operated coffee vending controller. Accumulates coins into a
//  saturating balance, starts a brew when the balance covers the price and
//  refunds the balance on request. All outputs are registered.
//
//  Optional feature: define COFFEE_TIMEOUT_EN to let COFFEE also exit after
//  TIMEOUT_CYCLES cycles without a coffee_out edge. Without the macro the
//  brew waits indefinitely and no timeout counter is built.
//
// Ports:
//  clk              in   system clock (100 MHz)
//  reset            in   asynchronous active-low reset
//  coin             in   coin sensor level, one rising edge = one coin
//  return_coin_btn  in   refund request level
//  coffee_btn       in   brew request level
//  coffee_out       in   brew-complete sensor level
//  coin_val         out  current balance, unsigned binary
//  seg_en           out  FND display enable
//  coffee_make      out  brewing active
//  coin_return      out  refund actuator pulse (RETURN_CYCLES long)
// -----------------------------------------------------------------------------
module coffee_machine
  import coffee_machine_pkg::*;
#(
  parameter int unsigned COIN_UNIT      = COIN_UNIT_DEF,
  parameter int unsigned PRICE          = PRICE_DEF,
  parameter int unsigned MAX_VAL        = MAX_VAL_DEF,
  parameter int unsigned RETURN_CYCLES  = RETURN_CYCLES_DEF
`ifdef COFFEE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin,
  input  logic        return_coin_btn,
  input  logic        coffee_btn,
  input  logic        coffee_out,
  output logic [15:0] coin_val,
  output logic        seg_en,
  output logic        coffee_make,
  output logic        coin_return
);

  localparam int unsigned RET_W = (RETURN_CYCLES > 1) ? $clog2(RETURN_CYCLES) : 1;
  localparam logic [RET_W-1:0] RET_LAST = RET_W'(RETURN_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input edge detection
  // ---------------------------------------------------------------------------
  logic coin_rise;
  logic ret_rise;
  logic coffee_rise;
  logic done_rise;

  rise_edge_det u_coin_edge   (.clk(clk), .rst_n(reset), .in_i(coin),            .pulse_o(coin_rise));
  rise_edge_det u_ret_edge    (.clk(clk), .rst_n(reset), .in_i(return_coin_btn), .pulse_o(ret_rise));
  rise_edge_det u_coffee_edge (.clk(clk), .rst_n(reset), .in_i(coffee_btn),      .pulse_o(coffee_rise));
  rise_edge_det u_done_edge   (.clk(clk), .rst_n(reset), .in_i(coffee_out),      .pulse_o(done_rise));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [15:0]      coin_val_q, coin_val_d;
  logic [RET_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             seg_en_q, seg_en_d;
  logic             coffee_make_q, coffee_make_d;
  logic             coin_return_q, coin_return_d;

  // Coin acceptance: a coin that would push the balance above MAX_VAL is
  // dropped, so the ceiling is reached exactly and never exceeded.
  logic [16:0] coin_sum;
  logic        coin_fits;
  logic        covers_price;

  assign coin_sum     = {1'b0, coin_val_q} + 17'(COIN_UNIT);
  assign coin_fits    = (coin_sum <= 17'(MAX_VAL));
  assign covers_price = (coin_val_q >= 16'(PRICE));

  // Brew completion: sensor edge, optionally also the timeout.
  logic brew_done;

`ifdef COFFEE_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_hit;

  assign timeout_hit = (state_q == COFFEE) && (to_cnt_q == TO_LAST);
  assign brew_done   = done_rise | timeout_hit;

  // Counts cycles spent in COFFEE; cleared on exit and outside COFFEE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else if ((state_q == COFFEE) && !brew_done) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  assign brew_done = done_rise;
`endif

  // Balance-based resting state used after a coin and after a brew.
  function automatic state_e settle(input logic [15:0] val);
    if (val >= 16'(PRICE)) begin
      return READY;
    end else if (val != '0) begin
      return COIN_IN;
    end else begin
      return IDLE;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    coin_val_d = coin_val_q;
    ret_cnt_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (coin_rise && coin_fits) begin
          coin_val_d = coin_sum[15:0];
          state_d    = settle(coin_val_d);
        end
      end

      COIN_IN, READY: begin
        // Refund wins over brew, brew wins over coin.
        if (ret_rise) begin
          state_d = COIN_OUT;
        end else if (coffee_rise && (state_q == READY) && covers_price) begin
          coin_val_d = coin_val_q - 16'(PRICE);
          state_d    = COFFEE;
        end else if (coin_rise && coin_fits) begin
          coin_val_d = coin_sum[15:0];
          state_d    = settle(coin_val_d);
        end
      end

      COFFEE: begin
        if (brew_done) begin
          state_d = settle(coin_val_q);
        end
      end

      COIN_OUT: begin
        if (ret_cnt_q == RET_LAST) begin
          coin_val_d = '0;
          state_d    = IDLE;
        end else begin
          ret_cnt_d = ret_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register together
    // with it and need no extra cycle of latency.
    seg_en_d      = (state_d != IDLE) || (coin_val_d != '0);
    coffee_make_d = (state_d == COFFEE);
    coin_return_d = (state_d == COIN_OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      coin_val_q    <= '0;
      ret_cnt_q     <= '0;
      seg_en_q      <= 1'b0;
      coffee_make_q <= 1'b0;
      coin_return_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      coin_val_q    <= coin_val_d;
      ret_cnt_q     <= ret_cnt_d;
      seg_en_q      <= seg_en_d;
      coffee_make_q <= coffee_make_d;
      coin_return_q <= coin_return_d;
    end
  end

  assign coin_val    = coin_val_q;
  assign seg_en      = seg_en_q;
  assign coffee_make = coffee_make_q;
  assign coin_return = coin_return_q;

endmodule

// File: tb/tb_coffee_machine.sv
// -----------------------------------------------------------------------------
// tb_coffee_machine
//  Directed self-checking bench for coffee_machine. Inputs change just after
//  the falling clock edge; outputs are sampled on the following falling edge,
//  i.e. half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_coffee_machine;
  import coffee_machine_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        coin;
  logic        return_coin_btn;
  logic        coffee_btn;
  logic        coffee_out;
  logic [15:0] coin_val;
  logic        seg_en;
  logic        coffee_make;
  logic        coin_return;

  int checks   = 0;
  int failures = 0;

  coffee_machine dut (
    .clk             (clk),
    .reset           (reset),
    .coin            (coin),
    .return_coin_btn (return_coin_btn),
    .coffee_btn      (coffee_btn),
    .coffee_out      (coffee_out),
    .coin_val        (coin_val),
    .seg_en          (seg_en),
    .coffee_make     (coffee_make),
    .coin_return     (coin_return)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_e exp);
    check(tag, 32'(dut.state_q), 32'(exp));
  endtask

  // Coin held 3 clk, then 10 idle clk.
  task automatic insert_coin();
    coin = 1'b1;
    tick(3);
    coin = 1'b0;
    tick(10);
  endtask

  // Coin held 1 clk, then 1 idle clk.
  task automatic fast_coin();
    coin = 1'b1;
    tick(1);
    coin = 1'b0;
    tick(1);
  endtask

  // One-clock button pulses; return sampled right after the effective edge.
  task automatic press_coffee();
    coffee_btn = 1'b1;
    tick(1);
    coffee_btn = 1'b0;
  endtask

  task automatic press_return();
    return_coin_btn = 1'b1;
    tick(1);
    return_coin_btn = 1'b0;
  endtask

  task automatic finish_brew();
    coffee_out = 1'b1;
    tick(1);
    coffee_out = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    coin            = 1'b0;
    return_coin_btn = 1'b0;
    coffee_btn      = 1'b0;
    coffee_out      = 1'b0;

    // 1: reset held ~100 ns then released
    tick(10);
    reset = 1'b1;
    tick(2);
    check("rst_coin_val", 32'(coin_val), 0);
    check("rst_seg_en", 32'(seg_en), 0);
    check("rst_coffee_make", 32'(coffee_make), 0);
    check("rst_coin_return", 32'(coin_return), 0);
    check_state("rst_state", IDLE);

    // 2: three coins; first one checked one cycle after it rises
    coin = 1'b1;
    tick(1);
    check("coin1_latency", 32'(coin_val), 100);
    check_state("coin1_state", COIN_IN);
    check("coin1_seg_en", 32'(seg_en), 1);
    tick(2);
    coin = 1'b0;
    tick(10);
    check("coin1_held_once", 32'(coin_val), 100);
    insert_coin();
    check("coin2_val", 32'(coin_val), 200);
    check_state("coin2_state", COIN_IN);
    insert_coin();
    check("coin3_val", 32'(coin_val), 300);
    check_state("coin3_state", READY);

    // 3: brew with exactly the price
    press_coffee();
    check("brew_make", 32'(coffee_make), 1);
    check("brew_val", 32'(coin_val), 0);
    check_state("brew_state", COFFEE);
    tick(20);
    check("brew_hold", 32'(coffee_make), 1);
    finish_brew();
    check("brew_done_make", 32'(coffee_make), 0);
    check_state("brew_done_state", IDLE);
    check("brew_done_val", 32'(coin_val), 0);
    check("brew_done_seg", 32'(seg_en), 0);

    // 4: 500 in, brew leaves 200 (below price -> COIN_IN), then refund
    repeat (5) insert_coin();
    check("five_coins", 32'(coin_val), 500);
    press_coffee();
    check("brew500_val", 32'(coin_val), 200);
    finish_brew();
    check("after500_val", 32'(coin_val), 200);
    check_state("after500_state", COIN_IN);
    check("after500_seg", 32'(seg_en), 1);
    press_return();
    check("refund_start", 32'(coin_return), 1);
    check_state("refund_state", COIN_OUT);
    tick(3);
    check("refund_4th_cycle", 32'(coin_return), 1);
    tick(1);
    check("refund_end", 32'(coin_return), 0);
    check("refund_val", 32'(coin_val), 0);
    check_state("refund_idle", IDLE);
    check("refund_seg", 32'(seg_en), 0);

    // 5: coffee below price, return in IDLE, coin during brew
    insert_coin();
    insert_coin();
    press_coffee();
    check("nobrew_make", 32'(coffee_make), 0);
    check("nobrew_val", 32'(coin_val), 200);
    check_state("nobrew_state", COIN_IN);
    press_return();
    tick(4);
    check_state("refund2_idle", IDLE);
    press_return();
    check("idle_return_pulse", 32'(coin_return), 0);
    check_state("idle_return_state", IDLE);
    tick(1);
    check("idle_return_later", 32'(coin_return), 0);
    repeat (3) insert_coin();
    press_coffee();
    coin = 1'b1;
    tick(1);
    coin = 1'b0;
    check("brew_coin_ignored", 32'(coin_val), 0);
    check_state("brew_coin_state", COFFEE);
    finish_brew();
    check_state("brew2_idle", IDLE);

    // 6: simultaneous return and coffee in READY -> refund wins
    repeat (4) insert_coin();
    check_state("four_ready", READY);
    coffee_btn      = 1'b1;
    return_coin_btn = 1'b1;
    tick(1);
    coffee_btn      = 1'b0;
    return_coin_btn = 1'b0;
    check_state("both_state", COIN_OUT);
    check("both_return", 32'(coin_return), 1);
    check("both_make", 32'(coffee_make), 0);
    check("both_val", 32'(coin_val), 400);
    tick(4);
    check_state("both_idle", IDLE);

    // Saturation at MAX_VAL
    repeat (99) fast_coin();
    check("sat_99", 32'(coin_val), 9900);
    fast_coin();
    check("sat_100_ignored", 32'(coin_val), 9900);
    check_state("sat_state", READY);
    press_return();
    tick(4);
    check("sat_refund", 32'(coin_val), 0);

    // Asynchronous reset mid-brew
    repeat (3) insert_coin();
    press_coffee();
    tick(3);
    check("pre_reset_make", 32'(coffee_make), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_make", 32'(coffee_make), 0);
    check("async_rst_val", 32'(coin_val), 0);
    check_state("async_rst_state", IDLE);
    check("async_rst_seg", 32'(seg_en), 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    check_state("post_reset_state", IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
